// File: rtl/rs_alu_station.sv
// ALU reservation station: DEPTH entries with CDB operand snooping, oldest-ready
// selection through an age matrix, and a single-cycle ALU feeding a registered result.
module rs_alu_station #(
    parameter int W     = 16,
    parameter int TAG_W = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [5:0]                 issue_op,
    input  logic [TAG_W-1:0]           issue_rob,
    input  logic [W-1:0]               issue_vj,
    input  logic [TAG_W-1:0]           issue_qj,
    input  logic                       issue_rj,
    input  logic [W-1:0]               issue_vk,
    input  logic [TAG_W-1:0]           issue_qk,
    input  logic                       issue_rk,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [W-1:0]               cdb_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [TAG_W-1:0]           res_tag,
    output logic [W-1:0]               res_data,
    output logic                       res_exc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int SH_W  = $clog2(W);

    localparam logic [5:0] OP_ADD  = 6'b000101;
    localparam logic [5:0] OP_SUB  = 6'b000110;
    localparam logic [5:0] OP_NOT  = 6'b001011;
    localparam logic [5:0] OP_AND  = 6'b001100;
    localparam logic [5:0] OP_OR   = 6'b001101;
    localparam logic [5:0] OP_XOR  = 6'b001110;
    localparam logic [5:0] OP_SHRA = 6'b001111;
    localparam logic [5:0] OP_SHRL = 6'b010000;
    localparam logic [5:0] OP_ROTL = 6'b010101;
    localparam logic [5:0] OP_ROTR = 6'b010110;

    logic [DEPTH-1:0] vld_q, vld_d, rj_q, rj_d, rk_q, rk_d, rdy;
    logic [5:0]       op_q  [DEPTH];
    logic [5:0]       op_d  [DEPTH];
    logic [TAG_W-1:0] rob_q [DEPTH];
    logic [TAG_W-1:0] rob_d [DEPTH];
    logic [TAG_W-1:0] qj_q  [DEPTH];
    logic [TAG_W-1:0] qj_d  [DEPTH];
    logic [TAG_W-1:0] qk_q  [DEPTH];
    logic [TAG_W-1:0] qk_d  [DEPTH];
    logic [W-1:0]     vj_q  [DEPTH];
    logic [W-1:0]     vj_d  [DEPTH];
    logic [W-1:0]     vk_q  [DEPTH];
    logic [W-1:0]     vk_d  [DEPTH];
    // older_q[i][j] = 1 means entry i was issued before entry j
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];

    logic             res_valid_q, res_valid_d, res_exc_q, res_exc_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic [W-1:0]     res_data_q, res_data_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [IDX_W-1:0] free_idx, sel_idx;
    logic             do_issue, do_disp, hit_j, hit_k;

    // Returns {exc, data}; unsupported opcodes yield a zero result with exc set.
    function automatic logic [W:0] alu_eval(input logic [5:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [SH_W-1:0]     sh;
        logic signed [W-1:0] sa;
        logic [2*W-1:0]      dbl;
        sh  = b[SH_W-1:0];
        sa  = a;
        dbl = {a, a};
        alu_eval = {1'b1, {W{1'b0}}};
        case (op)
            OP_ADD:  alu_eval = {1'b0, a + b};
            OP_SUB:  alu_eval = {1'b0, a - b};
            OP_NOT:  alu_eval = {1'b0, ~a};
            OP_AND:  alu_eval = {1'b0, a & b};
            OP_OR:   alu_eval = {1'b0, a | b};
            OP_XOR:  alu_eval = {1'b0, a ^ b};
            OP_SHRA: alu_eval = {1'b0, sa >>> sh};
            OP_SHRL: alu_eval = {1'b0, a >> sh};
            OP_ROTL: begin
                dbl = dbl << sh;
                alu_eval = {1'b0, dbl[2*W-1:W]};
            end
            OP_ROTR: begin
                dbl = dbl >> sh;
                alu_eval = {1'b0, dbl[W-1:0]};
            end
            default: alu_eval = {1'b1, {W{1'b0}}};
        endcase
    endfunction

    assign issue_ready = (occ_q < OCC_W'(DEPTH));

    always_comb begin
        logic oldest;
        rdy      = '0;
        free_idx = '0;
        sel_idx  = '0;
        oldest   = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld_q[i]) free_idx = IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = vld_q[i] && rj_q[i] && (rk_q[i] || op_q[i] == OP_NOT);
        end
        for (int i = 0; i < DEPTH; i++) begin
            oldest = rdy[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && rdy[j] && !older_q[i][j]) oldest = 1'b0;
            end
            if (oldest) sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        vld_d = vld_q;  op_d = op_q;  rob_d = rob_q;
        vj_d  = vj_q;   vk_d = vk_q;  qj_d  = qj_q;  qk_d = qk_q;
        rj_d  = rj_q;   rk_d = rk_q;  older_d = older_q;
        res_valid_d = res_valid_q;
        res_tag_d   = res_tag_q;
        res_data_d  = res_data_q;
        res_exc_d   = res_exc_q;
        do_issue = issue_valid && issue_ready;
        do_disp  = (|rdy) && (!res_valid_q || res_ready);
        hit_j    = cdb_valid && (cdb_tag == issue_qj);
        hit_k    = cdb_valid && (cdb_tag == issue_qk);
        occ_d    = occ_q + OCC_W'(do_issue) - OCC_W'(do_disp);

        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && cdb_valid) begin
                if (!rj_q[i] && qj_q[i] == cdb_tag) begin
                    rj_d[i] = 1'b1;
                    vj_d[i] = cdb_data;
                end
                if (!rk_q[i] && qk_q[i] == cdb_tag) begin
                    rk_d[i] = 1'b1;
                    vk_d[i] = cdb_data;
                end
            end
        end

        if (do_disp) begin
            vld_d[sel_idx] = 1'b0;
            res_valid_d    = 1'b1;
            res_tag_d      = rob_q[sel_idx];
            {res_exc_d, res_data_d} = alu_eval(op_q[sel_idx], vj_q[sel_idx], vk_q[sel_idx]);
            for (int j = 0; j < DEPTH; j++) begin
                older_d[sel_idx][j] = 1'b0;
                older_d[j][sel_idx] = 1'b0;
            end
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end

        // New entry is younger than every other entry
        if (do_issue) begin
            vld_d[free_idx] = 1'b1;
            op_d[free_idx]  = issue_op;
            rob_d[free_idx] = issue_rob;
            qj_d[free_idx]  = issue_qj;
            qk_d[free_idx]  = issue_qk;
            rj_d[free_idx]  = issue_rj || hit_j;
            rk_d[free_idx]  = issue_rk || hit_k;
            vj_d[free_idx]  = (!issue_rj && hit_j) ? cdb_data : issue_vj;
            vk_d[free_idx]  = (!issue_rk && hit_k) ? cdb_data : issue_vk;
            for (int j = 0; j < DEPTH; j++) begin
                older_d[j][free_idx] = 1'b1;
                older_d[free_idx][j] = 1'b0;
            end
        end

        if (flush) begin
            vld_d       = '0;
            res_valid_d = 1'b0;
            res_tag_d   = '0;
            res_data_d  = '0;
            res_exc_d   = 1'b0;
            occ_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q       <= '0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_data_q  <= '0;
            res_exc_q   <= 1'b0;
            occ_q       <= '0;
        end else begin
            vld_q       <= vld_d;
            res_valid_q <= res_valid_d;
            res_tag_q   <= res_tag_d;
            res_data_q  <= res_data_d;
            res_exc_q   <= res_exc_d;
            occ_q       <= occ_d;
        end
    end

    // Entry payload is qualified by vld_q, so it needs no reset
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        rob_q   <= rob_d;
        vj_q    <= vj_d;
        vk_q    <= vk_d;
        qj_q    <= qj_d;
        qk_q    <= qk_d;
        rj_q    <= rj_d;
        rk_q    <= rk_d;
        older_q <= older_d;
    end

    assign res_valid = res_valid_q;
    assign res_tag   = res_tag_q;
    assign res_data  = res_data_q;
    assign res_exc   = res_exc_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_rs_alu_station.sv
// Bench for rs_alu_station: ALU vector table, directed multi-cycle sequences and
// randomized traffic, all checked every cycle against an age-ordered queue model.
module tb_rs_alu_station;

    localparam int DEPTH = 4;

    localparam logic [5:0] OP_ADD  = 6'b000101;
    localparam logic [5:0] OP_SUB  = 6'b000110;
    localparam logic [5:0] OP_NOT  = 6'b001011;
    localparam logic [5:0] OP_AND  = 6'b001100;
    localparam logic [5:0] OP_OR   = 6'b001101;
    localparam logic [5:0] OP_XOR  = 6'b001110;
    localparam logic [5:0] OP_SHRA = 6'b001111;
    localparam logic [5:0] OP_SHRL = 6'b010000;
    localparam logic [5:0] OP_ROTL = 6'b010101;
    localparam logic [5:0] OP_ROTR = 6'b010110;
    localparam logic [5:0] OP_DIV  = 6'b001010;

    logic        clk = 1'b0;
    logic        reset, flush, issue_valid, issue_ready;
    logic [5:0]  issue_op;
    logic [4:0]  issue_rob, issue_qj, issue_qk, cdb_tag, res_tag;
    logic [15:0] issue_vj, issue_vk, cdb_data, res_data;
    logic        issue_rj, issue_rk, cdb_valid, res_valid, res_ready, res_exc;
    logic [2:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    rs_alu_station #(.W(16), .TAG_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_rob(issue_rob), .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_rj(issue_rj),
        .issue_vk(issue_vk), .issue_qk(issue_qk), .issue_rk(issue_rk),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
        .res_data(res_data), .res_exc(res_exc), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: entries kept in age order ----------------
    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rob, qj, qk;
        logic [15:0] vj, vk;
        bit          rj, rk;
    } ent_t;

    ent_t        mq[$];
    bit          m_rv;
    logic [4:0]  m_rt;
    logic [15:0] m_rd;
    bit          m_re;

    function automatic logic [16:0] ref_alu(logic [5:0] op, logic [15:0] a, logic [15:0] b);
        int ai, bi, sh, sa, r;
        bit exc;
        ai = int'(a); bi = int'(b); sh = bi % 16;
        sa = (ai >= 32768) ? ai - 65536 : ai;
        exc = 0; r = 0;
        case (op)
            OP_ADD:  r = ai + bi;
            OP_SUB:  r = ai - bi;
            OP_NOT:  r = 65535 - ai;
            OP_AND:  r = ai & bi;
            OP_OR:   r = ai | bi;
            OP_XOR:  r = ai ^ bi;
            OP_SHRA: r = sa >>> sh;
            OP_SHRL: r = ai >> sh;
            OP_ROTL: r = (ai << sh) | (ai >> (16 - sh));
            OP_ROTR: r = (ai >> sh) | (ai << (16 - sh));
            default: exc = 1;
        endcase
        r = r & 65535;
        return {exc, r[15:0]};
    endfunction

    function automatic void model_step();
        int sel, pre;
        logic [16:0] r;
        ent_t e;
        if (reset || flush) begin
            mq.delete();
            m_rv = 0; m_rt = 0; m_rd = 0; m_re = 0;
            return;
        end
        pre = mq.size();
        sel = -1;
        foreach (mq[i]) if (sel < 0 && mq[i].rj && (mq[i].rk || mq[i].op == OP_NOT)) sel = i;
        if ((!m_rv || res_ready) && sel >= 0) begin
            r = ref_alu(mq[sel].op, mq[sel].vj, mq[sel].vk);
            m_rv = 1; m_rt = mq[sel].rob; m_re = r[16]; m_rd = r[15:0];
            mq.delete(sel);
        end else if (res_ready) begin
            m_rv = 0;
        end
        if (cdb_valid) begin
            foreach (mq[i]) begin
                if (!mq[i].rj && mq[i].qj == cdb_tag) begin mq[i].rj = 1; mq[i].vj = cdb_data; end
                if (!mq[i].rk && mq[i].qk == cdb_tag) begin mq[i].rk = 1; mq[i].vk = cdb_data; end
            end
        end
        if (issue_valid && pre < DEPTH) begin
            e.op = issue_op; e.rob = issue_rob; e.qj = issue_qj; e.qk = issue_qk;
            e.vj = issue_vj; e.vk = issue_vk; e.rj = issue_rj; e.rk = issue_rk;
            if (!e.rj && cdb_valid && cdb_tag == e.qj) begin e.rj = 1; e.vj = cdb_data; end
            if (!e.rk && cdb_valid && cdb_tag == e.qk) begin e.rk = 1; e.vk = cdb_data; end
            mq.push_back(e);
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model_occupancy", occupancy, mq.size());
        chk("model_issue_ready", issue_ready, (mq.size() < DEPTH) ? 1 : 0);
        chk("model_res_valid", res_valid, m_rv);
        if (m_rv) begin
            chk("model_res_tag", res_tag, m_rt);
            chk("model_res_data", res_data, m_rd);
            chk("model_res_exc", res_exc, m_re);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic idle();
        issue_valid = 0; cdb_valid = 0; flush = 0; reset = 0;
    endtask

    task automatic drive_issue(input logic [5:0] op, input logic [4:0] rob,
                               input logic [15:0] vj, input logic [4:0] qj, input logic rj,
                               input logic [15:0] vk, input logic [4:0] qk, input logic rk);
        issue_valid = 1; issue_op = op; issue_rob = rob;
        issue_vj = vj; issue_qj = qj; issue_rj = rj;
        issue_vk = vk; issue_qk = qk; issue_rk = rk;
    endtask

    task automatic chk_idle_state(input string nm);
        chk({nm, "_res_valid"}, res_valid, 0);
        chk({nm, "_res_tag"}, res_tag, 0);
        chk({nm, "_res_data"}, res_data, 0);
        chk({nm, "_res_exc"}, res_exc, 0);
        chk({nm, "_occupancy"}, occupancy, 0);
        chk({nm, "_issue_ready"}, issue_ready, 1);
    endtask

    function automatic logic [5:0] pick_op(int n);
        case (n)
            0: return OP_ADD;   1: return OP_SUB;   2: return OP_NOT;
            3: return OP_AND;   4: return OP_OR;    5: return OP_XOR;
            6: return OP_SHRA;  7: return OP_SHRL;  8: return OP_ROTL;
            9: return OP_ROTR;  10: return OP_DIV;  default: return 6'b111111;
        endcase
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [15:0] vj, vk, exp;
        bit          exc;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{OP_ADD,  16'h0003, 16'h0004, 16'h0007, 1'b0};
        tbl[1]  = '{OP_ADD,  16'hFFFF, 16'h0002, 16'h0001, 1'b0};
        tbl[2]  = '{OP_SUB,  16'h0000, 16'h0001, 16'hFFFF, 1'b0};
        tbl[3]  = '{OP_NOT,  16'h00FF, 16'h1234, 16'hFF00, 1'b0};
        tbl[4]  = '{OP_AND,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b0};
        tbl[5]  = '{OP_OR,   16'hF000, 16'h000F, 16'hF00F, 1'b0};
        tbl[6]  = '{OP_XOR,  16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0};
        tbl[7]  = '{OP_SHRA, 16'h8000, 16'h000F, 16'hFFFF, 1'b0};
        tbl[8]  = '{OP_SHRA, 16'h7FF0, 16'h0004, 16'h07FF, 1'b0};
        tbl[9]  = '{OP_SHRL, 16'h8000, 16'h000F, 16'h0001, 1'b0};
        tbl[10] = '{OP_SHRL, 16'hF000, 16'h0013, 16'h1E00, 1'b0};
        tbl[11] = '{OP_ROTL, 16'h8001, 16'h0001, 16'h0003, 1'b0};
        tbl[12] = '{OP_ROTR, 16'h0003, 16'h0001, 16'h8001, 1'b0};
        tbl[13] = '{OP_ROTL, 16'h1234, 16'h0010, 16'h1234, 1'b0};
        tbl[14] = '{OP_DIV,  16'h0064, 16'h0005, 16'h0000, 1'b1};
        tbl[15] = '{6'b000000, 16'hAAAA, 16'h5555, 16'h0000, 1'b1};

        reset = 1; flush = 0; issue_valid = 0; cdb_valid = 0; res_ready = 1;
        issue_op = 0; issue_rob = 0; issue_vj = 0; issue_vk = 0;
        issue_qj = 0; issue_qk = 0; issue_rj = 0; issue_rk = 0;
        cdb_tag = 0; cdb_data = 0;
        m_rv = 0; m_rt = 0; m_rd = 0; m_re = 0;
        tick(); tick();
        chk_idle_state("reset");
        idle();

        // ALU vector table
        for (int i = 0; i < 16; i++) begin
            drive_issue(tbl[i].op, 5'(i), tbl[i].vj, 5'd0, 1'b1, tbl[i].vk, 5'd0, 1'b1);
            tick();
            idle();
            tick();
            chk($sformatf("vec%0d_valid", i), res_valid, 1);
            chk($sformatf("vec%0d_tag", i), res_tag, i);
            chk($sformatf("vec%0d_data", i), res_data, tbl[i].exp);
            chk($sformatf("vec%0d_exc", i), res_exc, tbl[i].exc);
        end
        tick();

        // T1: two-cycle latency
        drive_issue(OP_ADD, 5'd7, 16'd3, 5'd0, 1'b1, 16'd4, 5'd0, 1'b1);
        tick(); idle();
        chk("t1_not_early", res_valid, 0);
        tick();
        chk("t1_valid", res_valid, 1);
        chk("t1_tag", res_tag, 7);
        chk("t1_data", res_data, 7);
        tick();

        // T2: wait for qj=9 broadcast
        drive_issue(OP_SUB, 5'd2, 16'd0, 5'd9, 1'b0, 16'd1, 5'd0, 1'b1);
        tick(); idle();
        tick(); tick();
        chk("t2_waiting", res_valid, 0);
        cdb_valid = 1; cdb_tag = 5'd9; cdb_data = 16'h0010;
        tick(); idle();
        chk("t2_no_same_cycle_wakeup", res_valid, 0);
        tick();
        chk("t2_valid", res_valid, 1);
        chk("t2_data", res_data, 16'h000F);
        chk("t2_tag", res_tag, 2);
        tick();

        // T3: four entries released by one broadcast, retire in age order
        for (int i = 1; i <= 4; i++) begin
            drive_issue(OP_ADD, 5'(i), 16'd0, 5'd5, 1'b0, 16'(i), 5'd0, 1'b1);
            tick();
        end
        idle();
        chk("t3_full_ready", issue_ready, 0);
        chk("t3_full_occ", occupancy, 4);
        cdb_valid = 1; cdb_tag = 5'd5; cdb_data = 16'd10;
        tick(); idle();
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("t3_order%0d_tag", i), res_tag, i);
            chk($sformatf("t3_order%0d_data", i), res_data, 10 + i);
        end
        tick();
        chk("t3_drained", occupancy, 0);

        // T4: backpressure holds result and blocks dispatch
        res_ready = 0;
        drive_issue(OP_ADD, 5'd10, 16'd1, 5'd0, 1'b1, 16'd1, 5'd0, 1'b1);
        tick();
        drive_issue(OP_ADD, 5'd11, 16'd2, 5'd0, 1'b1, 16'd2, 5'd0, 1'b1);
        tick(); idle();
        chk("t4_first_tag", res_tag, 10);
        chk("t4_occ", occupancy, 1);
        tick(); tick();
        chk("t4_hold_valid", res_valid, 1);
        chk("t4_hold_tag", res_tag, 10);
        chk("t4_hold_data", res_data, 2);
        chk("t4_hold_occ", occupancy, 1);
        res_ready = 1;
        tick();
        chk("t4_second_tag", res_tag, 11);
        chk("t4_second_data", res_data, 4);
        tick();

        // T5: capture from CDB at issue, then arithmetic shift
        drive_issue(OP_SHRA, 5'd12, 16'd0, 5'd6, 1'b0, 16'd4, 5'd0, 1'b1);
        cdb_valid = 1; cdb_tag = 5'd6; cdb_data = 16'hFFFF;
        tick(); idle();
        tick();
        chk("t5_data", res_data, 16'hFFFF);
        chk("t5_tag", res_tag, 12);
        tick();

        // NOT ignores a pending k operand
        drive_issue(OP_NOT, 5'd13, 16'h0F0F, 5'd0, 1'b1, 16'd0, 5'd3, 1'b0);
        tick(); idle();
        tick();
        chk("not_k_pending_valid", res_valid, 1);
        chk("not_k_pending_data", res_data, 16'hF0F0);
        tick();

        // T6: flush with three entries and a held result; concurrent issue discarded
        res_ready = 0;
        for (int i = 0; i < 4; i++) begin
            drive_issue(OP_ADD, 5'(20 + i), 16'(i), 5'd0, 1'b1, 16'd1, 5'd0, 1'b1);
            tick();
        end
        chk("t6_pre_occ", occupancy, 3);
        chk("t6_pre_valid", res_valid, 1);
        drive_issue(OP_ADD, 5'd30, 16'd5, 5'd0, 1'b1, 16'd5, 5'd0, 1'b1);
        flush = 1;
        tick(); idle();
        chk_idle_state("t6_flush");
        res_ready = 1;
        tick(); tick();
        chk("t6_no_stale", res_valid, 0);
        chk("t6_discarded", occupancy, 0);

        // T6b: reset mid-run
        drive_issue(OP_XOR, 5'd1, 16'h1111, 5'd0, 1'b1, 16'h2222, 5'd0, 1'b1);
        tick();
        drive_issue(OP_ADD, 5'd2, 16'd0, 5'd8, 1'b0, 16'd0, 5'd0, 1'b1);
        tick(); idle();
        reset = 1;
        tick();
        reset = 0;
        chk_idle_state("t6b_reset");
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            issue_valid = ($urandom_range(0, 9) < 6);
            issue_op    = pick_op($urandom_range(0, 11));
            issue_rob   = 5'($urandom);
            issue_vj    = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            issue_vk    = 16'($urandom);
            issue_rj    = ($urandom_range(0, 2) != 0);
            issue_rk    = ($urandom_range(0, 2) != 0);
            issue_qj    = 5'($urandom_range(0, 7));
            issue_qk    = 5'($urandom_range(0, 7));
            cdb_valid   = ($urandom_range(0, 9) < 4);
            cdb_tag     = 5'($urandom_range(0, 7));
            cdb_data    = 16'($urandom);
            res_ready   = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 99) == 0);
            reset       = ($urandom_range(0, 299) == 0);
            tick();
        end
        idle();
        res_ready = 1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
